// File: rtl/hash_tte_lookup.sv
// Lookup front-end for the TTE flow-table hash bucket: folds {dmac, smac} into a
// bucket index, issues the bucket request with retry/timeout, and keeps hit/miss counts.
module hash_tte_lookup #(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              lk_req,
  input  logic [47:0]       lk_dmac,
  input  logic [47:0]       lk_smac,
  output logic              lk_ready,
  output logic              lk_ack,
  output logic              lk_nak,
  output logic              lk_err,
  output logic [15:0]       lk_portmap,
  output logic [47:0]       se_dmac,
  output logic [47:0]       se_smac,
  output logic [11:0]       se_hash,
  output logic              se_req,
  input  logic              se_ack,
  input  logic              se_nak,
  input  logic [15:0]       se_result,
  input  logic              bk_busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned MAC_W  = 48;
  localparam int unsigned HASH_W = 12;
  localparam int unsigned PM_W   = 16;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 2);
  localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HASH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    R_HIT,
    R_MISS,
    R_ERR
  } res_t;

  state_t              state_q, state_d;
  res_t                res_q, res_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [PM_W-1:0]     cap_q, cap_d;
  logic [MAC_W-1:0]    dmac_q, dmac_d, smac_q, smac_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic                ack_q, ack_d, nak_q, nak_d, err_q, err_d;
  logic [PM_W-1:0]     pm_q, pm_d;
  logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d;
  logic                se_req_c;

  // XOR-fold of the eight 12-bit slices of the two MACs
  function automatic logic [HASH_W-1:0] fold(input logic [MAC_W-1:0] d,
                                             input logic [MAC_W-1:0] s);
    return d[11:0] ^ d[23:12] ^ d[35:24] ^ d[47:36]
         ^ s[11:0] ^ s[23:12] ^ s[35:24] ^ s[47:36];
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      res_q   <= R_HIT;
      timer_q <= '0;
      retry_q <= '0;
      cap_q   <= '0;
      dmac_q  <= '0;
      smac_q  <= '0;
      hash_q  <= '0;
      ack_q   <= 1'b0;
      nak_q   <= 1'b0;
      err_q   <= 1'b0;
      pm_q    <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      cap_q   <= cap_d;
      dmac_q  <= dmac_d;
      smac_q  <= smac_d;
      hash_q  <= hash_d;
      ack_q   <= ack_d;
      nak_q   <= nak_d;
      err_q   <= err_d;
      pm_q    <= pm_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    cap_d    = cap_q;
    dmac_d   = dmac_q;
    smac_d   = smac_q;
    hash_d   = hash_q;
    ack_d    = 1'b0;
    nak_d    = 1'b0;
    err_d    = 1'b0;
    pm_d     = '0;
    hit_d    = hit_q;
    miss_d   = miss_q;
    se_req_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (lk_req) begin
          dmac_d  = lk_dmac;
          smac_d  = lk_smac;
          retry_d = '0;
          state_d = S_HASH;
        end
      end
      S_HASH: begin
        hash_d  = fold(dmac_q, smac_q);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // hold off while the bucket is clearing/updating
        if (!bk_busy) begin
          se_req_c = 1'b1;
          timer_d  = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        // a response on the timeout cycle takes priority over the re-issue
        if (se_nak) begin
          res_d   = R_MISS;
          state_d = S_DONE;
        end else if (se_ack) begin
          res_d   = R_HIT;
          cap_d   = se_result;
          state_d = S_DONE;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_ISSUE;
          end else begin
            res_d   = R_ERR;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (res_q == R_HIT) begin
          ack_d = 1'b1;
          pm_d  = cap_q;
          hit_d = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
        end else begin
          nak_d  = 1'b1;
          err_d  = (res_q == R_ERR);
          miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign lk_ready   = (state_q == S_IDLE);
  assign se_req     = se_req_c;
  assign lk_ack     = ack_q;
  assign lk_nak     = nak_q;
  assign lk_err     = err_q;
  assign lk_portmap = pm_q;
  assign se_dmac    = dmac_q;
  assign se_smac    = smac_q;
  assign se_hash    = hash_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_hash_tte_lookup.sv
// Self-checking bench for hash_tte_lookup: the bench plays classifier and bucket,
// predicting each lookup's request count, timing, outcome and counters from a reference model.
module tb_hash_tte_lookup;

  localparam int unsigned TIMEOUT   = 15;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  localparam int K_ACK    = 0;
  localparam int K_NAK    = 1;
  localparam int K_BOTH   = 2;
  localparam int K_SILENT = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             lk_req;
  logic [47:0]      lk_dmac, lk_smac;
  logic             lk_ready, lk_ack, lk_nak, lk_err;
  logic [15:0]      lk_portmap;
  logic [47:0]      se_dmac, se_smac;
  logic [11:0]      se_hash;
  logic             se_req, se_ack, se_nak, bk_busy;
  logic [15:0]      se_result;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  hash_tte_lookup #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .lk_req(lk_req), .lk_dmac(lk_dmac), .lk_smac(lk_smac),
    .lk_ready(lk_ready), .lk_ack(lk_ack), .lk_nak(lk_nak), .lk_err(lk_err),
    .lk_portmap(lk_portmap),
    .se_dmac(se_dmac), .se_smac(se_smac), .se_hash(se_hash), .se_req(se_req),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result), .bk_busy(bk_busy),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bucket index = XOR of all 12-bit slices of the 96-bit {dmac, smac}
  function automatic logic [11:0] ref_hash(input logic [47:0] d, input logic [47:0] s);
    logic [95:0] all;
    logic [11:0] h;
    all = {d, s};
    h = '0;
    for (int i = 0; i < 8; i++) h ^= 12'(all >> (12 * i));
    return h;
  endfunction

  function automatic logic [47:0] rand_mac();
    return 48'({$urandom(), $urandom()});
  endfunction

  // One lookup: accept in cycle 0; bucket answers request number resp_idx after delay cycles.
  task automatic run_lookup(input logic [47:0] dm, input logic [47:0] sm, input int kind,
                            input int delay, input int busy, input int resp_idx,
                            input bit hold, input bit stale, input logic [15:0] pm);
    int n_req, first_req, last_req, resp_cyc, stale_cyc, done_cyc;
    int exp_nreq, exp_first, exp_last, exp_done;
    bit err, exp_ack, bad_busy, bad_int, bad_hash;
    logic [11:0] eh, hash_first;
    logic [47:0] dmac_first, smac_first;
    logic g_ack, g_nak, g_err;
    logic [15:0] g_pm;

    eh        = ref_hash(dm, sm);
    err       = (kind == K_SILENT) || (resp_idx > int'(MAX_RETRY));
    exp_nreq  = err ? int'(MAX_RETRY) + 1 : resp_idx + 1;
    exp_ack   = !err && (kind == K_ACK);
    exp_first = (busy > 2) ? busy : 2;
    exp_last  = exp_first + (exp_nreq - 1) * (int'(TIMEOUT) + 2);
    exp_done  = err ? exp_last + int'(TIMEOUT) + 3 : exp_last + delay + 2;

    n_req = 0; first_req = -1; last_req = -1; resp_cyc = -1; stale_cyc = -1; done_cyc = -1;
    bad_busy = 0; bad_int = 0; bad_hash = 0;
    hash_first = '0; dmac_first = '0; smac_first = '0;
    g_ack = 0; g_nak = 0; g_err = 0; g_pm = '0;

    @(negedge clk);
    lk_req = 1'b1; lk_dmac = dm; lk_smac = sm;
    bk_busy = (busy > 0); se_ack = 1'b0; se_nak = 1'b0;

    for (int c = 1; c <= exp_done + 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      lk_req    = hold && (c < exp_done);
      lk_dmac   = rand_mac();
      lk_smac   = rand_mac();
      bk_busy   = (c < busy);
      se_ack    = ((c == resp_cyc) && (kind != K_NAK)) || (c == stale_cyc);
      se_nak    = (c == resp_cyc) && (kind != K_ACK);
      se_result = (c == resp_cyc) ? pm : 16'($urandom());
      #1;
      if (se_req) begin
        if (bk_busy) bad_busy = 1;
        if (se_hash !== eh) bad_hash = 1;
        if (n_req > 0 && (c - last_req) != int'(TIMEOUT) + 2) bad_int = 1;
        if (n_req == 0) begin
          first_req = c; hash_first = se_hash; dmac_first = se_dmac; smac_first = se_smac;
          if (stale && resp_idx > 0) stale_cyc = c + int'(TIMEOUT) + 2;
        end
        if (n_req == resp_idx && kind != K_SILENT) resp_cyc = c + delay;
        last_req = c;
        n_req++;
      end
      if (lk_ack || lk_nak) begin
        done_cyc = c; g_ack = lk_ack; g_nak = lk_nak; g_err = lk_err; g_pm = lk_portmap;
      end
    end
    se_ack = 1'b0; se_nak = 1'b0; bk_busy = 1'b0; lk_req = 1'b0;

    if (exp_ack) exp_hit  = (exp_hit  < CNT_MAX) ? exp_hit + 1  : CNT_MAX;
    else         exp_miss = (exp_miss < CNT_MAX) ? exp_miss + 1 : CNT_MAX;

    check("lookup_completed", 64'(done_cyc >= 0), 64'd1);
    check("se_hash", 64'(hash_first), 64'(eh));
    check("se_dmac", 64'(dmac_first), 64'(dm));
    check("se_smac", 64'(smac_first), 64'(sm));
    check("first_se_req_cycle", 64'(first_req), 64'(exp_first));
    check("se_req_count", 64'(n_req), 64'(exp_nreq));
    check("se_req_interval", 64'(bad_int), 64'd0);
    check("se_req_while_busy", 64'(bad_busy), 64'd0);
    check("se_hash_stable", 64'(bad_hash), 64'd0);
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("lk_ack", 64'(g_ack), 64'(exp_ack));
    check("lk_nak", 64'(g_nak), 64'(!exp_ack));
    check("lk_err", 64'(g_err), 64'(err));
    check("lk_portmap", 64'(g_pm), exp_ack ? 64'(pm) : 64'd0);
    check("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
    check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));

    @(negedge clk); #1;
    check("pulse_one_cycle", 64'(lk_ack | lk_nak | lk_err), 64'd0);
    check("ready_after_done", 64'(lk_ready), 64'd1);
  endtask

  initial begin
    int pulses, reqs;
    rstn = 1'b0; lk_req = 1'b0; lk_dmac = '0; lk_smac = '0;
    se_ack = 1'b0; se_nak = 1'b0; se_result = '0; bk_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_lk_ready", 64'(lk_ready), 64'd1);
    check("rst_pulses", 64'({lk_ack, lk_nak, lk_err, se_req}), 64'd0);
    check("rst_portmap", 64'(lk_portmap), 64'd0);
    check("rst_se_regs", 64'({se_dmac, se_smac, se_hash} != '0), 64'd0);
    check("rst_counters", 64'({hit_cnt, miss_cnt}), 64'd0);
    rstn = 1'b1;

    // directed cases
    run_lookup(48'h123456789ABC, 48'h0, K_ACK, 6, 0, 0, 0, 0, 16'h0004);
    check("t1_hash_const", 64'(se_hash), 64'h840);
    run_lookup(48'h000000000ABC, 48'h0, K_NAK, 3, 0, 0, 0, 0, 16'h0000);
    check("t2_hash_const", 64'(se_hash), 64'hABC);
    run_lookup(rand_mac(), rand_mac(), K_ACK, 2, 20, 0, 0, 0, 16'hBEEF);
    run_lookup(rand_mac(), rand_mac(), K_SILENT, 1, 0, 0, 0, 0, 16'h0);
    run_lookup(rand_mac(), rand_mac(), K_BOTH, 4, 0, 0, 0, 0, 16'h1234);
    run_lookup(rand_mac(), rand_mac(), K_ACK, int'(TIMEOUT) + 1, 0, 0, 0, 0, 16'h5A5A);
    run_lookup(rand_mac(), rand_mac(), K_NAK, 5, 0, 1, 1, 1, 16'h0);
    run_lookup(rand_mac(), rand_mac(), K_ACK, 3, 0, int'(MAX_RETRY), 1, 1, 16'h00F0);

    // randomized lookups
    for (int i = 0; i < 30; i++) begin
      int k, d, b, r;
      bit h, s;
      k = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, TIMEOUT + 1));
      b = int'($urandom_range(0, 6));
      r = int'($urandom_range(0, MAX_RETRY + 1));
      h = 1'($urandom());
      s = 1'($urandom());
      run_lookup(rand_mac(), rand_mac(), k, d, b, r, h, s, 16'($urandom()));
    end

    // drive hit counter into saturation
    for (int i = 0; i < CNT_MAX + 2; i++)
      run_lookup(rand_mac(), rand_mac(), K_ACK, 1, 0, 0, 0, 0, 16'($urandom()));
    check("hit_cnt_saturated", 64'(hit_cnt), 64'(CNT_MAX));

    // async reset while waiting on the bucket
    @(negedge clk);
    lk_req = 1'b1; lk_dmac = rand_mac(); lk_smac = rand_mac();
    @(negedge clk);
    lk_req = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    exp_hit = 0; exp_miss = 0;
    check("midrst_lk_ready", 64'(lk_ready), 64'd1);
    check("midrst_pulses", 64'({lk_ack, lk_nak, lk_err, se_req}), 64'd0);
    check("midrst_se_regs", 64'({se_dmac, se_smac, se_hash} != '0), 64'd0);
    check("midrst_counters", 64'({hit_cnt, miss_cnt}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0; reqs = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      se_ack = (c < 3); se_result = 16'hFFFF;
      #1;
      if (lk_ack || lk_nak) pulses++;
      if (se_req) reqs++;
    end
    se_ack = 1'b0;
    check("late_ack_no_pulse", 64'(pulses), 64'd0);
    check("late_ack_no_req", 64'(reqs), 64'd0);
    check("late_ack_hit_cnt", 64'(hit_cnt), 64'(exp_hit));
    check("late_ack_ready", 64'(lk_ready), 64'd1);

    // a normal lookup still works after the reset
    run_lookup(rand_mac(), rand_mac(), K_ACK, 7, 0, 0, 0, 0, 16'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
